// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and widths for the pong match sequencer
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } pong_state_e;

    localparam int STATE_W      = 3;
    localparam int SCORE_W      = 4;
    localparam int DELAY_W      = 8;
    localparam int TICK_DIV_DEF = 50000;

endpackage

// File: rtl/pong_game_sequencer_if.sv
// rtl/pong_game_sequencer_if.sv - control/status bundle between pin decode, sequencer and physics
interface pong_game_sequencer_if;
    import pong_pkg::*;

    logic               ena;
    logic               start;
    logic               miss_left;
    logic               miss_right;
    logic               phys_step;
    logic               phys_serve;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic [STATE_W-1:0] state;
    logic               game_over;

    modport master (
        output ena, start, miss_left, miss_right,
        input  phys_step, phys_serve, serve_dir, score_left, score_right, state, game_over
    );

    modport slave (
        input  ena, start, miss_left, miss_right,
        output phys_step, phys_serve, serve_dir, score_left, score_right, state, game_over
    );

endinterface

// File: rtl/pong_tick_div.sv
// rtl/pong_tick_div.sv - free-running game tick divider with hold on ena low
module pong_tick_div
    import pong_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic tick
);

    localparam int                CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= ena && (cnt_q == CNT_MAX);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pong_game_sequencer.sv
// rtl/pong_game_sequencer.sv - match FSM: serve delay, rally play, scoring and game over
module pong_game_sequencer
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int SERVE_DELAY = 32,
    parameter int WIN_SCORE   = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pong_game_sequencer_if.slave  bus
);

    localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(SERVE_DELAY);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    pong_state_e        state_q, state_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               dir_q, dir_d;
    logic               start_q;
    logic               armed_q;
    logic               tick;
    logic               start_rise;
    logic               step;
    logic               serve;

    pong_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (bus.ena),
        .tick  (tick)
    );

    // armed_q blocks a start level held high across reset release from looking like an edge
    assign start_rise = bus.start & ~start_q & armed_q;

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        dir_d     = dir_q;
        step      = 1'b0;
        serve     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                score_l_d = '0;
                score_r_d = '0;
                if (start_rise) begin
                    delay_d = DELAY_LOAD;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    delay_d = delay_q - DELAY_W'(1);
                    if (delay_q == DELAY_W'(1)) begin
                        serve   = 1'b1;
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                step = tick;
                if (bus.miss_left && !bus.miss_right) begin
                    score_r_d = score_r_q + SCORE_W'(1);
                    dir_d     = 1'b0;
                end else if (bus.miss_right && !bus.miss_left) begin
                    score_l_d = score_l_q + SCORE_W'(1);
                    dir_d     = 1'b1;
                end
                if (bus.miss_left || bus.miss_right) begin
                    state_d = ST_POINT;
                end
            end
            ST_POINT: begin
                if (score_l_q == WIN || score_r_q == WIN) begin
                    state_d = ST_OVER;
                end else begin
                    delay_d = DELAY_LOAD;
                    state_d = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    delay_d   = DELAY_LOAD;
                    state_d   = ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            delay_q   <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            dir_q     <= 1'b0;
            start_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            dir_q     <= dir_d;
            start_q   <= bus.start;
            armed_q   <= 1'b1;
        end
    end

    assign bus.phys_step   = step;
    assign bus.phys_serve  = serve;
    assign bus.serve_dir   = dir_q;
    assign bus.score_left  = score_l_q;
    assign bus.score_right = score_r_q;
    assign bus.state       = state_q;
    assign bus.game_over   = (state_q == ST_OVER);

endmodule
